// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the instruction cache (port 0) and the data cache (port 1)
// share one 256-bit off-chip memory interface. Exactly one whole line
// transaction is in flight at a time: grant, hold the request to memory, wait
// for mem_ack_i, then return the ack and the read line to the winner. The
// losing port gets no ack and stays stalled in its own cache FSM.
//
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking. When it is
// not defined, port 1 (dcache) always wins a tie.
//
// Ports:
//   clk_i, rst_i          rising-edge clock, synchronous active-high reset
//   pN_enable_i/write_i   port N request and direction (1 = write)
//   pN_addr_i/data_i      port N line address and write line
//   pN_data_o/ack_o       read line and completion pulse back to port N
//   mem_enable_o/write_o  registered request to memory
//   mem_addr_o/data_o     registered address and write line to memory
//   mem_data_i/ack_i      read line and one-cycle completion from memory
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [LINE_W-1:0] p0_data_i,
  output logic [LINE_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [LINE_W-1:0] p1_data_i,
  output logic [LINE_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_data_q, mem_data_d;
  logic                any_req;
  logic                winner;

  assign any_req = p0_enable_i | p1_enable_i;

`ifdef MEM_ARB_RR_EN
  // last = most recently granted port; on a tie the other port wins.
  logic last_q, last_d;

  always_comb begin
    if (p0_enable_i && p1_enable_i) winner = ~last_q;
    else                            winner = p1_enable_i;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && any_req) last_d = winner;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= 1'b0;
    else       last_q <= last_d;
  end
`else
  // Port 1 whenever it asks, otherwise port 0.
  assign winner = p1_enable_i;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          // Snapshot the winner's request; memory sees it from the next cycle.
          state_d      = BUSY;
          grant_d      = winner;
          mem_enable_d = 1'b1;
          mem_write_d  = winner ? p1_write_i : p0_write_i;
          mem_addr_d   = winner ? p1_addr_i  : p0_addr_i;
          mem_data_d   = winner ? p1_data_i  : p0_data_i;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d      = DONE;
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
          mem_addr_d   = '0;
          mem_data_d   = '0;
        end
      end
      DONE: begin
        // Bubble so the acked requester can drop or change its request.
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_data_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  // Acks outside BUSY (spurious, or late after a reset) are dropped here.
  assign p0_ack_o  = mem_ack_i & (state_q == BUSY) & ~grant_q;
  assign p1_ack_o  = mem_ack_i & (state_q == BUSY) &  grant_q;
  assign p0_data_o = p0_ack_o ? mem_data_i : '0;
  assign p1_data_o = p1_ack_o ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 time unit later. Directed scenarios come first, then a
// randomized run checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk, rst;
  logic         p0_en, p0_we, p0_ack, p1_en, p1_we, p1_ack;
  logic [31:0]  p0_addr, p1_addr, mem_addr;
  logic [255:0] p0_wd, p0_rd, p1_wd, p1_rd, mem_wd, mem_rd;
  logic         mem_en, mem_we, mem_ack;

  int checks   = 0;
  int failures = 0;
  bit exp_last = 1'b0;  // model of the most recently granted port

  mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_enable_i(p0_en), .p0_write_i(p0_we), .p0_addr_i(p0_addr), .p0_data_i(p0_wd),
    .p0_data_o(p0_rd), .p0_ack_o(p0_ack),
    .p1_enable_i(p1_en), .p1_write_i(p1_we), .p1_addr_i(p1_addr), .p1_data_i(p1_wd),
    .p1_data_o(p1_rd), .p1_ack_o(p1_ack),
    .mem_enable_o(mem_en), .mem_write_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wd), .mem_data_i(mem_rd), .mem_ack_i(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset;
    @(negedge clk); #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wd, p0_ack, p1_ack, p0_rd, p1_rd} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got en=%b we=%b addr=%h ack=%b%b want all zero",
               mem_en, mem_we, mem_addr, p0_ack, p1_ack);
    end
    @(negedge clk); rst = 1'b0;
    exp_last = 1'b0;
  endtask

  task automatic test_spurious;
    @(negedge clk); mem_ack = 1'b1; mem_rd = rnd_line(); #1;
    checks++;
    if ({p0_ack, p1_ack, p0_rd, p1_rd} !== '0) begin
      failures++;
      $display("FAIL spurious_ack got acks=%b%b want 00", p0_ack, p1_ack);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ack = 1'b0; #1;
      checks++;
      if ({mem_en, mem_we, mem_addr, p0_ack, p1_ack} !== '0) begin
        failures++;
        $display("FAIL spurious_state got en=%b addr=%h want 0", mem_en, mem_addr);
      end
    end
  endtask

  task automatic test_single_read;
    logic [255:0] line;
    line = {32{8'hA5}};
    @(negedge clk); p0_en = 1'b1; p0_we = 1'b0; p0_addr = 32'h400; p0_wd = rnd_line(); #1;
    checks++;
    if (mem_en !== 1'b0) begin
      failures++; $display("FAIL read_req_cycle got en=%b want 0", mem_en);
    end
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 10) begin mem_ack = 1'b1; mem_rd = line; end
      else mem_rd = rnd_line();
      #1;
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wd} !== {1'b1, 1'b0, 32'h400, p0_wd}) begin
        failures++;
        $display("FAIL read_busy cyc=%0d got en=%b we=%b addr=%h want 1 0 00000400",
                 i, mem_en, mem_we, mem_addr);
      end
      checks++;
      if ({p0_ack, p1_ack, p0_rd} !== {(i == 10), 1'b0, (i == 10) ? line : 256'h0}) begin
        failures++;
        $display("FAIL read_ack cyc=%0d got acks=%b%b data=%h", i, p0_ack, p1_ack, p0_rd);
      end
    end
    @(negedge clk); mem_ack = 1'b0; mem_rd = rnd_line(); p0_en = 1'b0; #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wd, p0_ack, p1_ack, p0_rd} !== '0) begin
      failures++;
      $display("FAIL read_done got en=%b addr=%h ack=%b want 0", mem_en, mem_addr, p0_ack);
    end
    exp_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    int lat;
    logic [255:0] line;
    line = {8{32'h12345678}};
    lat  = $urandom_range(1, 6);
    @(negedge clk); p1_en = 1'b1; p1_we = 1'b1; p1_addr = 32'h200; p1_wd = line;
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      if (i == lat) begin mem_ack = 1'b1; mem_rd = '0; end
      else mem_rd = rnd_line();
      #1;
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wd} !== {1'b1, 1'b1, 32'h200, line}) begin
        failures++;
        $display("FAIL write_busy cyc=%0d got en=%b we=%b addr=%h data=%h",
                 i, mem_en, mem_we, mem_addr, mem_wd);
      end
      checks++;
      if ({p0_ack, p1_ack, p1_rd} !== {1'b0, (i == lat), 256'h0}) begin
        failures++;
        $display("FAIL write_ack cyc=%0d got acks=%b%b data=%h", i, p0_ack, p1_ack, p1_rd);
      end
    end
    @(negedge clk); mem_ack = 1'b0; p1_en = 1'b0; p1_we = 1'b0; #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wd, p0_ack, p1_ack} !== '0) begin
      failures++;
      $display("FAIL write_done got en=%b we=%b addr=%h want 0", mem_en, mem_we, mem_addr);
    end
    exp_last = 1'b1;
    @(negedge clk);
  endtask

  // p1 is granted before the reset, so a tie afterwards also shows last was cleared.
  task automatic test_reset_mid;
    @(negedge clk); p1_en = 1'b1; p1_we = 1'b0; p1_addr = 32'h5000;
    @(negedge clk); #1;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h5000}) begin
      failures++; $display("FAIL rst_mid_busy got en=%b addr=%h", mem_en, mem_addr);
    end
    exp_last = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; p1_en = 1'b0; #1;
    exp_last = 1'b0;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wd, p0_ack, p1_ack, p0_rd, p1_rd} !== '0) begin
      failures++;
      $display("FAIL rst_mid_zero got en=%b addr=%h want 0", mem_en, mem_addr);
    end
    @(negedge clk); mem_ack = 1'b1; mem_rd = rnd_line(); #1;
    checks++;
    if ({p0_ack, p1_ack, mem_en, p0_rd, p1_rd} !== '0) begin
      failures++;
      $display("FAIL rst_mid_late_ack got acks=%b%b en=%b", p0_ack, p1_ack, mem_en);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ack = 1'b0; #1;
      checks++;
      if ({mem_en, mem_addr} !== '0) begin
        failures++; $display("FAIL rst_mid_idle cyc=%0d got en=%b", i, mem_en);
      end
    end
  endtask

  task automatic test_tie;
    int n;
    bit ep;
    logic [31:0] ea;
    @(negedge clk);
    p0_en = 1'b1; p0_we = 1'b0; p0_addr = 32'h1000;
    p1_en = 1'b1; p1_we = 1'b0; p1_addr = 32'h2000;
    for (int t = 0; t < 4; t++) begin
      // Fourth transaction: p1 has dropped out, only p0 is still asking.
      if (t == 3) ep = 1'b0;
      else        ep = RR ? ~exp_last : 1'b1;
      ea = ep ? p1_addr : p0_addr;
      n = 0;
      do begin @(negedge clk); #1; n++; end while (mem_en !== 1'b1 && n < 20);
      checks++;
      if ({mem_en, mem_addr} !== {1'b1, ea}) begin
        failures++;
        $display("FAIL tie_grant t=%0d got en=%b addr=%h want addr=%h", t, mem_en, mem_addr, ea);
      end
      @(negedge clk); mem_ack = 1'b1; mem_rd = rnd_line(); #1;
      checks++;
      if ({p0_ack, p1_ack} !== {~ep, ep}) begin
        failures++;
        $display("FAIL tie_ack t=%0d got acks=%b%b want %b%b", t, p0_ack, p1_ack, ~ep, ep);
      end
      exp_last = ep;
      @(negedge clk); mem_ack = 1'b0;
      if (ep) begin
        if (t < 2) p1_addr = p1_addr + 32'h10; else p1_en = 1'b0;
      end else begin
        if (t < 3) p0_addr = p0_addr + 32'h10; else p0_en = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_busy_req;
    @(negedge clk); p1_en = 1'b1; p1_we = 1'b0; p1_addr = 32'h3000;
    @(negedge clk); @(negedge clk); @(negedge clk);
    @(negedge clk); p0_en = 1'b1; p0_we = 1'b0; p0_addr = 32'h4000; #1;
    checks++;
    if ({mem_en, mem_addr, p0_ack} !== {1'b1, 32'h3000, 1'b0}) begin
      failures++; $display("FAIL busy_hold got en=%b addr=%h", mem_en, mem_addr);
    end
    @(negedge clk); mem_ack = 1'b1; mem_rd = rnd_line(); #1;
    checks++;
    if ({p0_ack, p1_ack} !== 2'b01) begin
      failures++; $display("FAIL busy_p1_ack got acks=%b%b want 01", p0_ack, p1_ack);
    end
    @(negedge clk); mem_ack = 1'b0; p1_en = 1'b0; #1;
    checks++;
    if (mem_en !== 1'b0) begin
      failures++; $display("FAIL busy_done got en=%b want 0", mem_en);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_en !== 1'b0) begin
      failures++; $display("FAIL busy_idle got en=%b want 0", mem_en);
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h4000}) begin
      failures++;
      $display("FAIL busy_regrant got en=%b addr=%h want 1 00004000", mem_en, mem_addr);
    end
    exp_last = 1'b0;
    @(negedge clk); mem_ack = 1'b1; mem_rd = rnd_line(); #1;
    checks++;
    if ({p0_ack, p1_ack, p0_rd} !== {2'b10, mem_rd}) begin
      failures++; $display("FAIL busy_p0_ack got acks=%b%b", p0_ack, p1_ack);
    end
    @(negedge clk); mem_ack = 1'b0; p0_en = 1'b0;
    @(negedge clk);
  endtask

  // Transaction-level model: a request pending on a cycle when the arbiter is
  // free (no line in flight and at least two cycles past the last ack) starts a
  // transaction visible on the next cycle, winner chosen by the tie policy.
  task automatic test_random(input int ncyc);
    bit           pend[2];
    bit           we[2];
    logic [31:0]  ad[2];
    logic [255:0] wd[2];
    int           gap[2];
    bit           infl, start, gp, c_p, c_we, g_we, ack_now, e0, e1;
    logic [31:0]  c_ad, g_ad;
    logic [255:0] c_wd, g_wd;
    logic [289:0] exp_mem;
    int           lat, last_ack, c;
    infl = 0; start = 0; gp = 0; lat = 0; last_ack = -10; c = 0;
    for (int p = 0; p < 2; p++) begin pend[p] = 0; gap[p] = $urandom_range(0, 3); end
    while ((c < ncyc || pend[0] || pend[1] || infl || start) && c < ncyc + 300) begin
      @(negedge clk);
      if (start) begin
        infl = 1; start = 0; gp = c_p; g_we = c_we; g_ad = c_ad; g_wd = c_wd;
        lat = $urandom_range(0, 5); exp_last = c_p;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && c < ncyc) begin
          if (gap[p] == 0) begin
            pend[p] = 1; we[p] = ($urandom & 1) != 0; ad[p] = $urandom; wd[p] = rnd_line();
          end else gap[p]--;
        end
      end
      p0_en = pend[0]; p0_we = we[0]; p0_addr = ad[0]; p0_wd = wd[0];
      p1_en = pend[1]; p1_we = we[1]; p1_addr = ad[1]; p1_wd = wd[1];
      mem_ack = 1'b0; mem_rd = rnd_line();
      if (infl) begin
        if (lat == 0) begin mem_ack = 1'b1; if (g_we) mem_rd = '0; end
        else lat--;
      end else mem_ack = ($urandom_range(0, 7) == 0);
      #1;
      ack_now = mem_ack && infl;
      e0 = ack_now && !gp;
      e1 = ack_now && gp;
      exp_mem = infl ? {1'b1, g_we, g_ad, g_wd} : 290'h0;
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wd} !== exp_mem) begin
        failures++;
        $display("FAIL rand_mem cyc=%0d got en=%b we=%b addr=%h want en=%b we=%b addr=%h",
                 c, mem_en, mem_we, mem_addr, exp_mem[289], exp_mem[288], exp_mem[287:256]);
      end
      checks++;
      if ({p0_ack, p1_ack, p0_rd, p1_rd} !== {e0, e1, e0 ? mem_rd : 256'h0, e1 ? mem_rd : 256'h0}) begin
        failures++;
        $display("FAIL rand_ack cyc=%0d got acks=%b%b want %b%b", c, p0_ack, p1_ack, e0, e1);
      end
      if (ack_now) begin
        infl = 0; last_ack = c; pend[gp] = 0; gap[gp] = $urandom_range(0, 4);
      end
      if (!infl && c >= last_ack + 2 && (pend[0] || pend[1])) begin
        c_p   = (pend[0] && pend[1]) ? (RR ? ~exp_last : 1'b1) : pend[1];
        c_we  = we[c_p]; c_ad = ad[c_p]; c_wd = wd[c_p];
        start = 1;
      end
      c++;
    end
    checks++;
    if (pend[0] || pend[1] || infl || start) begin
      failures++;
      $display("FAIL rand_drain got pending=%b%b inflight=%b want all served", pend[0], pend[1], infl);
    end
    @(negedge clk); p0_en = 1'b0; p1_en = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rd = '0;
    p0_en = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wd = '0;
    p1_en = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wd = '0;
    test_reset;
    test_spurious;
    test_single_read;
    test_single_write;
    test_reset_mid;
    test_tie;
    test_busy_req;
    test_random(800);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 256-bit off-chip data memory interface between the instruction cache (port 0) and the data cache (port 1). It sits between the two cache tops and the memory model. It sequences one whole line transaction at a time: grant, hold request to memory, wait for `mem_ack_i`, then route the ack and read line back to the winner. Losing requesters see no ack and remain stalled by their own cache FSM.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `LINE_W`, 256, cache line width

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  synchronous active-high reset
- `p0_enable_i`  in  1  port 0 request
- `p0_write_i`  in  1  port 0 write (1) / read (0)
- `p0_addr_i`  in  ADDR_W  port 0 line address
- `p0_data_i`  in  LINE_W  port 0 write line
- `p0_data_o`  out  LINE_W  read line to port 0
- `p0_ack_o`  out  1  port 0 transaction complete
- `p1_*`  same set as port 0, for port 1
- `mem_enable_o`  out  1  request to memory
- `mem_write_o`  out  1  memory write
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_data_o`  out  LINE_W  memory write line
- `mem_data_i`  in  LINE_W  memory read line
- `mem_ack_i`  in  1  memory completion, one-cycle pulse

## Operation
- Requester contract: `pN_enable_i`, `pN_write_i`, `pN_addr_i` and `pN_data_i` are held stable from assertion until the cycle `pN_ack_o` is seen. The requester deasserts or changes them on the following cycle.
- FSM states:
  - IDLE: no transaction in flight. If any `pN_enable_i` is high, latch the winner into `grant` (1 bit) and go to BUSY. Otherwise stay in IDLE.
  - BUSY: drive the granted port's request to memory. On `mem_ack_i`, go to DONE. Otherwise stay in BUSY.
  - DONE: one bubble cycle, so the acked requester can drop its enable. Always go to IDLE.
- Memory outputs are registered:
  - In BUSY, `mem_enable_o`=1 and `mem_write_o`/`mem_addr_o`/`mem_data_o` are copies of the granted port's inputs, captured at the IDLE→BUSY edge.
  - In IDLE and DONE, all memory outputs are 0.
- Ack routing is combinational: `pN_ack_o` = `mem_ack_i` & (state==BUSY) & (grant==N).
- `pN_data_o` = `mem_data_i` when `pN_ack_o`, else 0.
- A `mem_ack_i` seen outside BUSY is ignored and produces no port ack.
- A requester that drops enable while granted is not a legal stimulus. The transaction still completes to memory.

## Timing
- Reset: the FSM goes to IDLE. `grant`=0, `last`=0, and every output is 0 on the first cycle after `rst_i` is sampled high.
- A reset during BUSY abandons the transaction immediately. A late `mem_ack_i` afterwards is ignored.
- Latency:
  - A request seen in IDLE at cycle T gives `mem_enable_o`=1 at T+1.
  - A `mem_ack_i` at cycle A gives `pN_ack_o` at A (same cycle), DONE at A+1, and IDLE at A+2.
  - The earliest next grant is at A+2, with `mem_enable_o` at A+3.
- Simultaneous requests in IDLE are resolved by the arbitration policy (see Configuration). A request arriving while BUSY waits. No request is dropped.
- A write transaction produces no port read data, but `p*_ack_o` still pulses.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A register `last` records the most recently granted port, updated on each IDLE→BUSY transition.
  - On a tie, the port ≠ `last` wins.
  - After reset `last`=0, so the first tie goes to port 1.
- Not defined: fixed priority, port 1 (dcache) always wins a tie. `last` is not implemented.

## Test plan
- Single read, port 0 only:
  - Stimulus: `p0_enable_i`=1, `p0_addr_i`=0x0000_0400, write=0; memory acks 10 cycles after `mem_enable_o` rises, with `mem_data_i`=0xA5…A5.
  - Required: `mem_addr_o`=0x400 and `mem_write_o`=0 throughout BUSY; `p0_ack_o` is a one-cycle pulse with `p0_data_o`=0xA5…A5; `p1_ack_o` stays 0; `mem_enable_o`=0 in DONE.
- Single write, port 1:
  - Stimulus: `p1_addr_i`=0x0000_0200, `p1_data_i`=0x1234…; memory acks.
  - Required: `mem_write_o`=1 and `mem_data_o`=0x1234… during BUSY; `p1_ack_o` pulses once; `p1_data_o`=0.
- Tie at IDLE, both ports request and hold until acked:
  - With `MEM_ARB_RR_EN`: grant order is p1, p0, p1 across three transactions, with p1 re-requesting immediately after each ack.
  - Without it: p1 is served first and on every subsequent tie, and p0 is served only when p1 is idle.
- Request during BUSY:
  - Stimulus: p0 requests 3 cycles into a p1 transaction.
  - Required: p0 is granted exactly 2 cycles after p1's ack cycle, and `mem_addr_o` switches to p0's address at that edge.
- Reset mid-transaction:
  - Stimulus: `rst_i` asserted in BUSY for 1 cycle, then `mem_ack_i` pulses.
  - Required: all outputs are 0 the cycle after reset; no `p*_ack_o` pulses; the FSM remains in IDLE.
- Spurious ack:
  - Stimulus: `mem_ack_i`=1 while in IDLE.
  - Required: no port ack, and no state change.
